// File: rtl/carus_sram_banked_ctrl.sv
// Banked SRAM controller with per-bank idle retention and wake sequencing (CARUS_SRAM_AUTO_RETENTION_EN enables it).
// Grant is same-cycle to an ACTIVE bank and read data follows one cycle later; requests to a sleeping bank stall until it wakes.

module sram_wrapper #(
  parameter int NUM_WORDS  = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [$clog2(NUM_WORDS)-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [DATA_WIDTH/8-1:0]       be_i,
  input  logic                          set_retentive_ni,
  output logic [DATA_WIDTH-1:0]         rdata_o
);
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic                  access;

  // A retentive macro keeps its contents but ignores accesses.
  assign access = req_i && set_retentive_ni;

  always_ff @(posedge clk_i) begin
    if (access && we_i) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (access && !we_i) begin
      rdata_o <= mem[addr_i];
    end
  end
endmodule

module carus_sram_banked_ctrl #(
  parameter int NUM_WORDS   = 4096,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_BANKS   = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [$clog2(NUM_WORDS)-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [DATA_WIDTH/8-1:0]       be_i,
  output logic                          gnt_o,
  output logic                          rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [NUM_BANKS-1:0]          bank_active_o
);
  localparam int AddrWidth = $clog2(NUM_WORDS);
  localparam int BankSelW  = $clog2(NUM_BANKS);
  localparam int RowW      = AddrWidth - BankSelW;
  localparam int BankWords = NUM_WORDS / NUM_BANKS;

  if ((NUM_WORDS % NUM_BANKS) != 0 || NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 ||
      IDLE_CYCLES < 1 || WAKE_CYCLES < 1 || (DATA_WIDTH % 8) != 0) begin : g_bad_cfg
    $error("carus_sram_banked_ctrl: invalid parameter set");
  end

  logic [BankSelW-1:0]   bank_sel;
  logic [RowW-1:0]       row;
  logic [NUM_BANKS-1:0]  bank_ok;
  logic [NUM_BANKS-1:0]  set_ret_n;
  logic [NUM_BANKS-1:0]  macro_req;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic                  rvalid_q;
  logic [BankSelW-1:0]   rbank_q;

  assign bank_sel = addr_i[AddrWidth-1 -: BankSelW];
  assign row      = addr_i[RowW-1:0];

`ifdef CARUS_SRAM_AUTO_RETENTION_EN
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_RETENT = 2'd1;
  localparam logic [1:0] ST_WAKE   = 2'd2;
  localparam int IdleW = $clog2(IDLE_CYCLES + 1);
  localparam int WakeW = $clog2(WAKE_CYCLES + 1);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_pwr
    logic [1:0]       state;
    logic [IdleW-1:0] idle_cnt;
    logic [WakeW-1:0] wake_cnt;
    logic             target;

    assign target = req_i && (bank_sel == BankSelW'(b));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state    <= ST_ACTIVE;
        idle_cnt <= '0;
        wake_cnt <= '0;
      end else begin
        case (state)
          ST_ACTIVE: begin
            // A request in the expiry cycle keeps the bank awake.
            if (target) begin
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + IdleW'(1);
              if (idle_cnt == IdleW'(IDLE_CYCLES - 1)) state <= ST_RETENT;
            end
          end
          ST_RETENT: begin
            if (target) begin
              state    <= ST_WAKE;
              wake_cnt <= WakeW'(WAKE_CYCLES);
            end
          end
          ST_WAKE: begin
            // Completes regardless of whether the requester is still waiting.
            wake_cnt <= wake_cnt - WakeW'(1);
            if (wake_cnt == WakeW'(1)) begin
              state    <= ST_ACTIVE;
              idle_cnt <= '0;
            end
          end
          default: begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
          end
        endcase
      end
    end

    assign bank_ok[b]   = (state == ST_ACTIVE);
    assign set_ret_n[b] = (state != ST_RETENT);
  end
`else
  assign bank_ok   = '1;
  assign set_ret_n = '1;
`endif

  assign gnt_o         = req_i && bank_ok[bank_sel];
  assign bank_active_o = bank_ok;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign macro_req[b] = gnt_o && (bank_sel == BankSelW'(b));

    sram_wrapper #(
      .NUM_WORDS  (BankWords),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
      .clk_i            (clk_i),
      .rst_ni           (~rst_i),
      .req_i            (macro_req[b]),
      .we_i             (we_i),
      .addr_i           (row),
      .wdata_i          (wdata_i),
      .be_i             (be_i),
      .set_retentive_ni (set_ret_n[b]),
      .rdata_o          (bank_rdata[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rbank_q  <= '0;
    end else begin
      rvalid_q <= gnt_o && !we_i;
      if (gnt_o && !we_i) rbank_q <= bank_sel;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rvalid_q ? bank_rdata[rbank_q] : '0;
endmodule

// File: tb/tb_carus_sram_banked_ctrl.sv
// Directed bench for carus_sram_banked_ctrl covering both builds of CARUS_SRAM_AUTO_RETENTION_EN.

module tb_carus_sram_banked_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [3:0]  bank_active;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [12:0] vecs [6];

`ifdef CARUS_SRAM_AUTO_RETENTION_EN
  localparam bit Ret = 1'b1;
`else
  localparam bit Ret = 1'b0;
`endif
  localparam int WakeStall = Ret ? 3 : 0;

  always #5 clk = ~clk;

  carus_sram_banked_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .we_i          (we),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .be_i          (be),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .bank_active_o (bank_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge following the grant.
  task automatic access(input string tag, input logic w, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int exp_stall);
    int stall;
    stall = 0;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    while (!gnt && stall < 20) begin
      @(posedge clk);
      #2;
      stall++;
    end
    if (!gnt) check({tag, "_gnt_timeout"}, 32'(gnt), 32'd1);
    else      check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] b, input int exp_stall);
    access(tag, 1'b1, a, d, b, exp_stall);
    check({tag, "_no_rvalid"}, 32'(rvalid), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [11:0] a, input logic [31:0] exp_data,
                         input int exp_stall);
    access(tag, 1'b0, a, 32'h0, 4'h0, exp_stall);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp_data);
  endtask

  initial begin
    vecs = '{13'h1005, 13'h0400, 13'h1800, 13'h1C00, 13'h0C00, 13'h1401};

    wait_cycles(3);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bank_active", 32'(bank_active), 32'hF);
    rst = 1'b0;

    // Fresh out of reset every bank is ACTIVE, so grant follows request.
    for (int i = 0; i < 6; i++) begin
      req = vecs[i][12];
      addr = vecs[i][11:0];
      #1;
      check($sformatf("gnt_eq_req_%0d", i), 32'(gnt), 32'(vecs[i][12]));
      wait_cycles(1);
    end
    req = 1'b0;

    do_write("wr_basic", 12'h005, 32'hDEADBEEF, 4'hF, 0);
    do_read("rd_basic", 12'h005, 32'hDEADBEEF, 0);
    wait_cycles(1);
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("rdata_zero", rdata, 32'd0);

    do_write("wr_full", 12'h006, 32'hFFFFFFFF, 4'hF, 0);
    do_write("wr_part", 12'h006, 32'h11223344, 4'h5, 0);
    do_read("rd_part", 12'h006, 32'hFF22FF44, 0);

    // Bank 0 last accessed at T; now at T+1.
    wait_cycles(15);
    check("b0_active_t16", 32'(bank_active[0]), 32'd1);
    wait_cycles(1);
    check("b0_retent_t17", 32'(bank_active[0]), 32'(!Ret));
    do_read("rd_wake", 12'h005, 32'hDEADBEEF, WakeStall);
    check("b0_active_after_wake", 32'(bank_active[0]), 32'd1);

    check("b3_asleep", 32'(bank_active[3]), 32'(!Ret));
    do_write("wr_b3", 12'hC01, 32'hA5A50003, 4'hF, WakeStall);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) do_read($sformatf("alt_b0_%0d", i), 12'h005, 32'hDEADBEEF, 0);
      else            do_read($sformatf("alt_b3_%0d", i), 12'hC01, 32'hA5A50003, 0);
    end
    check("alt_b0_active", 32'(bank_active[0]), 32'd1);
    check("alt_b3_active", 32'(bank_active[3]), 32'd1);

    // Request lands in the cycle the idle counter would expire.
    do_read("b0_touch", 12'h005, 32'hDEADBEEF, 0);
    wait_cycles(15);
    do_read("b0_expiry_hit", 12'h005, 32'hDEADBEEF, 0);
    check("b0_expiry_active", 32'(bank_active[0]), 32'd1);
    wait_cycles(15);
    check("b0_cnt_cleared", 32'(bank_active[0]), 32'd1);
    wait_cycles(1);
    check("b0_retent_again", 32'(bank_active[0]), 32'(!Ret));

    // Reset while bank 0 is waking.
    req = 1'b1; we = 1'b0; addr = 12'h005;
    #1;
    check("wake_req_gnt", 32'(gnt), 32'(!Ret));
    wait_cycles(1);
    rst = 1'b1; req = 1'b0;
    wait_cycles(1);
    check("rst_wake_rvalid", 32'(rvalid), 32'd0);
    check("rst_wake_active", 32'(bank_active), 32'hF);
    rst = 1'b0;

    // Reset coincident with a read grant discards the return.
    wait_cycles(1);
    req = 1'b1; we = 1'b0; addr = 12'hC01; rst = 1'b1;
    #1;
    check("rst_grant_gnt", 32'(gnt), 32'd1);
    wait_cycles(1);
    check("rst_grant_rvalid", 32'(rvalid), 32'd0);
    check("rst_grant_rdata", rdata, 32'd0);
    rst = 1'b0; req = 1'b0;
    wait_cycles(1);
    do_read("rd_after_rst", 12'hC01, 32'hA5A50003, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
